// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file defaults and clear-FSM state encoding
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REGS_DEF = 8;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register pending-bit scoreboard with set/clear/clear-all and three query ports
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit R0_ZERO = 1'b1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_all,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [2:0][ADDR_W-1:0] q_addr,
  output logic [2:0]             q_pend
);
  logic [NUM_REGS-1:0] pend, pend_n;
  always_comb begin
    pend_n = pend;
    if (clr_en) pend_n[clr_addr] = 1'b0;
    if (set_en) pend_n[set_addr] = 1'b1;
    if (clr_all) pend_n = '0;
    if (R0_ZERO) pend_n[0] = 1'b0;
  end
  always_ff @(posedge clk) pend <= rst ? '0 : pend_n;
  for (genvar q = 0; q < 3; q++) begin : g_q
    assign q_pend[q] = pend[q_addr[q]];
  end
endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: general-purpose register file with write-through bypass, issue scoreboard and sequential clear
module gpr_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit R0_ZERO = 1'b1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_stall,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              clr_start,
  output logic              clr_busy
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [2:0] pend_q;
  logic wr_ok, iss_ok;
  assign clr_busy = state == CLEAR;
  assign wr_ok = wr_en && !clr_busy && !(R0_ZERO && wr_addr == '0);
  assign iss_stall = (pend_q[0] && !(wr_en && wr_addr == iss_addr)) || clr_busy;
  assign iss_ok = iss_en && !iss_stall && !(R0_ZERO && iss_addr == '0);
  assign rd_busy_1 = (pend_q[1] && !(wr_en && wr_addr == rd_addr_1)) || clr_busy;
  assign rd_busy_2 = (pend_q[2] && !(wr_en && wr_addr == rd_addr_2)) || clr_busy;
  assign rd_data_1 = (R0_ZERO && rd_addr_1 == '0) ? '0 : (wr_ok && wr_addr == rd_addr_1) ? wr_data : regs[rd_addr_1];
  assign rd_data_2 = (R0_ZERO && rd_addr_2 == '0) ? '0 : (wr_ok && wr_addr == rd_addr_2) ? wr_data : regs[rd_addr_2];
  always_comb state_n = clr_busy ? ((cnt == ADDR_W'(NUM_REGS - 1)) ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= clr_busy ? cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) regs <= '{default: '0};
    else if (clr_busy) regs[cnt] <= '0;
    else if (wr_ok) regs[wr_addr] <= wr_data;
  end
  regfile_sb #(.NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (!clr_busy && clr_start),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .q_addr   ({rd_addr_2, rd_addr_1, iss_addr}),
    .q_pend   (pend_q)
  );
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed scoreboard bench for gpr_file_sb
module tb_gpr_file_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int S_RD1 = 0, S_RD2 = 1, S_BZ1 = 2, S_BZ2 = 3, S_STL = 4, S_CLR = 5;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, iss_en = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] wr_addr = '0, iss_addr = '0, rd_addr_1 = '0, rd_addr_2 = '0;
  logic [DW-1:0] wr_data = '0;
  logic iss_stall, rd_busy_1, rd_busy_2, clr_busy;
  logic [DW-1:0] rd_data_1, rd_data_2;
  int errs = 0, checks = 0;
  typedef struct {string tag; int sig; logic [DW-1:0] val;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  gpr_file_sb dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_busy_1 (rd_busy_1),
    .rd_busy_2 (rd_busy_2),
    .clr_start (clr_start),
    .clr_busy  (clr_busy)
  );
  function automatic logic [DW-1:0] obs(int s);
    case (s)
      S_RD1: return rd_data_1;
      S_RD2: return rd_data_2;
      S_BZ1: return {15'b0, rd_busy_1};
      S_BZ2: return {15'b0, rd_busy_2};
      S_STL: return {15'b0, iss_stall};
      default: return {15'b0, clr_busy};
    endcase
  endfunction
  task automatic exp_push(input string tag, input int sig, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    logic [DW-1:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.val) else begin
        errs++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    iss_en = 1'b0;
    clr_start = 1'b0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask
  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i += 2) begin
      step();
      rd_addr_1 = AW'(i);
      rd_addr_2 = AW'(i + 1);
      exp_push({tag, "_rd1"}, S_RD1, '0);
      exp_push({tag, "_rd2"}, S_RD2, '0);
      exp_push({tag, "_bz1"}, S_BZ1, '0);
      exp_push({tag, "_bz2"}, S_BZ2, '0);
      drain();
    end
  endtask
  initial begin
    step();
    iss_addr = 3'd1;
    rd_addr_1 = 3'd3;
    exp_push("rst_clr_busy", S_CLR, '0);
    exp_push("rst_stall", S_STL, '0);
    exp_push("rst_rd1", S_RD1, '0);
    exp_push("rst_bz1", S_BZ1, '0);
    drain();
    wr(3'd3, 16'h1234);
    step();
    rd_addr_1 = 3'd3;
    rd_addr_2 = 3'd3;
    exp_push("r3_rd1", S_RD1, 16'h1234);
    exp_push("r3_rd2", S_RD2, 16'h1234);
    exp_push("r3_bz1", S_BZ1, '0);
    exp_push("r3_bz2", S_BZ2, '0);
    drain();
    wr(3'd5, 16'hBEEF);
    rd_addr_1 = 3'd5;
    rd_addr_2 = 3'd5;
    exp_push("byp_rd1", S_RD1, 16'hBEEF);
    exp_push("byp_rd2", S_RD2, 16'hBEEF);
    drain();
    step();
    iss_en = 1'b1;
    iss_addr = 3'd2;
    exp_push("iss2_first_stall", S_STL, '0);
    drain();
    step();
    iss_en = 1'b1;
    iss_addr = 3'd2;
    rd_addr_1 = 3'd2;
    exp_push("iss2_busy", S_BZ1, 16'h1);
    exp_push("iss2_second_stall", S_STL, 16'h1);
    drain();
    wr(3'd2, 16'h0042);
    iss_addr = 3'd2;
    rd_addr_1 = 3'd2;
    exp_push("wb2_busy", S_BZ1, '0);
    exp_push("wb2_byp", S_RD1, 16'h0042);
    exp_push("wb2_stall", S_STL, '0);
    drain();
    step();
    rd_addr_1 = 3'd2;
    exp_push("r2_rd", S_RD1, 16'h0042);
    exp_push("r2_bz", S_BZ1, '0);
    drain();
    wr(3'd4, 16'h0777);
    iss_en = 1'b1;
    iss_addr = 3'd4;
    step();
    rd_addr_1 = 3'd4;
    exp_push("r4_data", S_RD1, 16'h0777);
    exp_push("r4_pend", S_BZ1, 16'h1);
    drain();
    wr(3'd4, 16'h0777);
    wr(3'd0, 16'hAAAA);
    iss_en = 1'b1;
    iss_addr = 3'd0;
    rd_addr_1 = 3'd0;
    exp_push("r0_byp", S_RD1, '0);
    exp_push("r0_bz_wr", S_BZ1, '0);
    drain();
    step();
    iss_addr = 3'd0;
    rd_addr_1 = 3'd0;
    exp_push("r0_rd", S_RD1, '0);
    exp_push("r0_bz", S_BZ1, '0);
    exp_push("r0_stall", S_STL, '0);
    drain();
    step();
    iss_en = 1'b1;
    iss_addr = 3'd5;
    @(negedge clk);
    rst = 1'b1;
    step();
    rd_addr_1 = 3'd5;
    rd_addr_2 = 3'd3;
    exp_push("rst_pend5", S_BZ1, '0);
    exp_push("rst_r3", S_RD2, '0);
    drain();
    for (int i = 0; i < 8; i++) wr(AW'(i), 16'hFFFF);
    step();
    rd_addr_1 = 3'd7;
    exp_push("fill_r7", S_RD1, 16'hFFFF);
    drain();
    step();
    clr_start = 1'b1;
    exp_push("clr_start_idle", S_CLR, '0);
    drain();
    for (int k = 0; k < 8; k++) begin
      step();
      wr_en = 1'b1;
      wr_addr = 3'd7;
      wr_data = 16'h1111;
      iss_en = 1'b1;
      iss_addr = 3'd6;
      clr_start = 1'b1;
      rd_addr_1 = 3'd7;
      rd_addr_2 = AW'(k);
      exp_push("clr_busy", S_CLR, 16'h1);
      exp_push("clr_stall", S_STL, 16'h1);
      exp_push("clr_bz1", S_BZ1, 16'h1);
      exp_push("clr_r7", S_RD1, 16'hFFFF);
      exp_push("clr_cur", S_RD2, (k == 0) ? 16'h0 : 16'hFFFF);
      drain();
    end
    step();
    exp_push("clr_done", S_CLR, '0);
    drain();
    read_all_zero("after_clr");
    for (int i = 1; i < 8; i++) wr(AW'(i), 16'h5A5A);
    step();
    clr_start = 1'b1;
    step();
    step();
    exp_push("abort_in_clear", S_CLR, 16'h1);
    drain();
    @(negedge clk);
    rst = 1'b1;
    step();
    iss_addr = 3'd6;
    exp_push("abort_clr_busy", S_CLR, '0);
    exp_push("abort_stall", S_STL, '0);
    drain();
    step();
    exp_push("abort_stays_idle", S_CLR, '0);
    drain();
    read_all_zero("after_abort");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
